reg_writeback_ctrl: RTL

REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

---
 rtl/reg_writeback_ctrl_if.sv | 32 +++
 rtl/reg_writeback_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/reg_writeback_ctrl_if.sv
// Writeback-controller signal bundle: ALU result, load issue/response, hazard query and
// register-file write port. The slave modport is the controller's view.
interface reg_writeback_ctrl_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_resp_valid;
  logic [4:0]  ld_resp_rd;
  logic [31:0] ld_resp_data;
  logic        ld_resp_ready;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic        stall;
  logic [31:0] pending;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_Data;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
    output ld_resp_valid, ld_resp_rd, ld_resp_data, chk_rs, chk_rt,
    input  ld_resp_ready, stall, pending, RegWrite, Write_register, Write_Data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
    input  ld_resp_valid, ld_resp_rd, ld_resp_data, chk_rs, chk_rt,
    output ld_resp_ready, stall, pending, RegWrite, Write_register, Write_Data
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Register-file writeback arbiter: ALU results take priority, load responses queue in a FIFO,
// and a per-register scoreboard tracks outstanding loads. Optional macro: WB_LOAD_BYPASS_EN.
module reg_writeback_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                 CLK,
  input logic                 RESET,
  reg_writeback_ctrl_if.slave bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  typedef logic [PtrW-1:0] ptr_t;

  logic [CntW-1:0] cnt_q, cnt_d;
  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic [4:0]      rd_mem   [FIFO_DEPTH];
  logic [31:0]     data_mem [FIFO_DEPTH];

  logic [31:0] pending_q, pending_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_register_q, write_register_d;
  logic [31:0] write_data_q, write_data_d;

  logic        ready, empty, accept, bypass, push, pop;
  logic        sel_valid, sel_load;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  // Ready depends on the registered count only, so a pop never frees space for a same-cycle push.
  assign ready  = (cnt_q < Depth);
  assign empty  = (cnt_q == '0);
  assign accept = bus.ld_resp_valid & ready;

`ifdef WB_LOAD_BYPASS_EN
  assign bypass = accept & ~bus.alu_valid & empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept & ~bypass;
  assign pop  = ~bus.alu_valid & ~empty;

  always_comb begin
    sel_valid = 1'b0;
    sel_load  = 1'b0;
    sel_rd    = bus.alu_rd;
    sel_data  = bus.alu_data;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = rd_mem[rd_ptr_q];
      sel_data  = data_mem[rd_ptr_q];
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_rd    = bus.ld_resp_rd;
      sel_data  = bus.ld_resp_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Issue is applied after the retire-clear so a same-cycle re-issue keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (sel_load) pending_d[sel_rd] = 1'b0;
    if (bus.ld_issue && (bus.ld_issue_rd != 5'd0)) pending_d[bus.ld_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    reg_write_d      = sel_valid & (sel_rd != 5'd0);
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    if (sel_valid) begin
      write_register_d = sel_rd;
      write_data_d     = sel_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      pending_q        <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
    end else begin
      cnt_q            <= cnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      pending_q        <= pending_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  // Storage needs no reset; the count and pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= bus.ld_resp_rd;
      data_mem[wr_ptr_q] <= bus.ld_resp_data;
    end
  end

  assign bus.ld_resp_ready  = ready;
  assign bus.stall          = pending_q[bus.chk_rs] | pending_q[bus.chk_rt];
  assign bus.pending        = pending_q;
  assign bus.RegWrite       = reg_write_q;
  assign bus.Write_register = write_register_q;
  assign bus.Write_Data     = write_data_q;

endmodule
